sga_uc: RTL and testbench

Control unit for the Snake Game Arcade. It sequences the `SGA_FD` datapath: size counter, render counter, apple register and direction capture. It also paces snake movement with an internal tick timer and reports win/lose status. It sits beside `SGA_FD` in the `SGA` top level, with every control output wired to the matching datapath input.

---
 rtl/sga_pkg.sv | 21 ++
 rtl/sga_uc_if.sv | 33 +++
 rtl/sga_move_timer.sv | 23 ++
 rtl/sga_uc.sv | 83 ++++++++
 tb/tb_sga_uc.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade control unit.
package sga_pkg;

  localparam int MOVE_TICKS_DEF = 50_000_000;
  localparam int TIMER_W_DEF    = 26;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    PREPARA      = 4'd1,
    NOVA_MACA    = 4'd2,
    RENDERIZA    = 4'd3,
    ESPERA       = 4'd4,
    MOVE         = 4'd5,
    VERIFICA     = 4'd6,
    CRESCE       = 4'd7,
    LIMPA_RENDER = 4'd8,
    PERDEU       = 4'd9,
    GANHOU       = 4'd10
  } sga_state_e;

endpackage

// File: rtl/sga_uc_if.sv
// Control/status bundle between the control unit (slave) and the datapath side (master).
interface sga_uc_if;
  logic       jogar;
  logic       restart;
  logic [3:0] buttons;
  logic       render_finish;
  logic       apple_eaten;
  logic       collision;
  logic       max_size;
  logic       clear_size;
  logic       count_size;
  logic       render_clr;
  logic       render_count;
  logic       register_apple;
  logic       reset_apple;
  logic       register_direction;
  logic       move_snake;
  logic       game_over;
  logic       won;
  logic [3:0] db_estado;

  modport master (
    output jogar, restart, buttons, render_finish, apple_eaten, collision, max_size,
    input  clear_size, count_size, render_clr, render_count, register_apple,
           reset_apple, register_direction, move_snake, game_over, won, db_estado
  );

  modport slave (
    input  jogar, restart, buttons, render_finish, apple_eaten, collision, max_size,
    output clear_size, count_size, render_clr, render_count, register_apple,
           reset_apple, register_direction, move_snake, game_over, won, db_estado
  );
endinterface

// File: rtl/sga_move_timer.sv
// Snake step pacing counter; done flags the last cycle of a step period.
module sga_move_timer #(
  parameter int MOVE_TICKS = 50_000_000,
  parameter int TIMER_W    = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + TIMER_W'(1);
  end

  assign done = (count_q == TIMER_W'(MOVE_TICKS - 1));

endmodule

// File: rtl/sga_uc.sv
// Snake Game Arcade control unit: sequences the datapath and paces snake steps.
//  state        | meaning
//  INICIAL      | idle, waiting for jogar
//  PREPARA      | clear size, render counter and apple
//  NOVA_MACA    | latch a new apple position
//  LIMPA_RENDER | clear render counter
//  RENDERIZA    | walk the snake body until render_finish
//  ESPERA       | step delay, capture direction buttons
//  MOVE         | advance the snake one cell
//  VERIFICA     | check collision / apple
//  CRESCE       | grow the snake
//  PERDEU       | game lost
//  GANHOU       | game won
module sga_uc
  import sga_pkg::*;
#(
  parameter int MOVE_TICKS = MOVE_TICKS_DEF,
  parameter int TIMER_W    = TIMER_W_DEF
) (
  input logic   clock,
  input logic   reset,
  sga_uc_if.slave bus
);

  sga_state_e state_q, state_d;
  logic       timer_done;
  logic       timer_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:      if (bus.jogar) state_d = PREPARA;
      PREPARA:      state_d = NOVA_MACA;
      NOVA_MACA:    state_d = LIMPA_RENDER;
      LIMPA_RENDER: state_d = RENDERIZA;
      RENDERIZA:    if (bus.render_finish) state_d = ESPERA;
      ESPERA:       if (timer_done) state_d = MOVE;
      MOVE:         state_d = VERIFICA;
      VERIFICA: begin
        if (bus.collision)        state_d = PERDEU;
        else if (bus.apple_eaten) state_d = CRESCE;
        else                      state_d = LIMPA_RENDER;
      end
      CRESCE:       state_d = bus.max_size ? GANHOU : NOVA_MACA;
      PERDEU,
      GANHOU:       if (bus.jogar) state_d = PREPARA;
      default:      state_d = INICIAL;
    endcase
    if (bus.restart && state_q != INICIAL) state_d = PREPARA;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Timer only runs while ESPERA persists, so any exit (including restart) leaves it at zero.
  assign timer_en = (state_q == ESPERA) && (state_d == ESPERA);

  sga_move_timer #(
    .MOVE_TICKS (MOVE_TICKS),
    .TIMER_W    (TIMER_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!timer_en),
    .enable (timer_en),
    .done   (timer_done)
  );

  assign bus.clear_size         = (state_q == PREPARA);
  assign bus.reset_apple        = (state_q == PREPARA);
  assign bus.render_clr         = (state_q == PREPARA) || (state_q == LIMPA_RENDER);
  assign bus.register_apple     = (state_q == NOVA_MACA);
  assign bus.count_size         = (state_q == CRESCE);
  assign bus.move_snake         = (state_q == MOVE);
  assign bus.game_over          = (state_q == PERDEU);
  assign bus.won                = (state_q == GANHOU);
  assign bus.render_count       = (state_q == RENDERIZA) && !bus.render_finish;
  assign bus.register_direction = (state_q == ESPERA) && (|bus.buttons);
  assign bus.db_estado          = state_q;

endmodule

// File: tb/tb_sga_uc.sv
// Self-checking bench for sga_uc with MOVE_TICKS=4.
module tb_sga_uc;
  localparam int MT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  sga_uc_if bus();

  sga_uc #(.MOVE_TICKS(MT), .TIMER_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int n_rc = 0, n_esp = 0, n_cs = 0, n_clr = 0, n_ra = 0, n_rd = 0, n_mv = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural reference: game phase as an integer code plus cycles spent waiting.
  int m_state = 0;
  int m_wait  = 0;

  function automatic int model_next(int s, int w);
    if (bus.restart && s != 0) return 1;
    if (s == 0)  return bus.jogar ? 1 : 0;
    if (s == 1)  return 2;
    if (s == 2)  return 8;
    if (s == 8)  return 3;
    if (s == 3)  return bus.render_finish ? 4 : 3;
    if (s == 4)  return (w + 1 >= MT) ? 5 : 4;
    if (s == 5)  return 6;
    if (s == 6)  return bus.collision ? 9 : (bus.apple_eaten ? 7 : 8);
    if (s == 7)  return bus.max_size ? 10 : 2;
    if (s == 9 || s == 10) return bus.jogar ? 1 : s;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    int nx;
    if (!reset) begin
      m_state = 0;
      m_wait  = 0;
    end else begin
      nx      = model_next(m_state, m_wait);
      m_wait  = (nx == 4 && m_state == 4) ? m_wait + 1 : 0;
      m_state = nx;
    end
  end

  // bits: clear_size count_size render_clr register_apple reset_apple move_snake game_over won
  function automatic logic [7:0] exp_moore(int s);
    logic [7:0] tbl [0:15];
    for (int i = 0; i < 16; i++) tbl[i] = 8'h00;
    tbl[1]  = 8'b1010_1000;
    tbl[2]  = 8'b0001_0000;
    tbl[8]  = 8'b0010_0000;
    tbl[5]  = 8'b0000_0100;
    tbl[7]  = 8'b0100_0000;
    tbl[9]  = 8'b0000_0010;
    tbl[10] = 8'b0000_0001;
    return tbl[s[3:0]];
  endfunction

  function automatic logic [7:0] dut_moore();
    return {bus.clear_size, bus.count_size, bus.render_clr, bus.register_apple,
            bus.reset_apple, bus.move_snake, bus.game_over, bus.won};
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      chk("state", int'(bus.db_estado), m_state);
      chk("moore_outs", int'(dut_moore()), int'(exp_moore(m_state)));
      chk("render_count", int'(bus.render_count), int'(m_state == 3 && !bus.render_finish));
      chk("register_direction", int'(bus.register_direction), int'(m_state == 4 && |bus.buttons));
      n_rc  += int'(bus.render_count);
      n_esp += int'(bus.db_estado == 4'd4);
      n_cs  += int'(bus.count_size);
      n_clr += int'(bus.clear_size);
      n_ra  += int'(bus.reset_apple);
      n_rd  += int'(bus.register_direction);
      n_mv  += int'(bus.move_snake);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic wait_state(input int code, input int lim);
    int k = 0;
    while (int'(bus.db_estado) != code && k < lim) begin
      cyc(1);
      k++;
    end
    chk("wait_state", int'(bus.db_estado), code);
  endtask

  initial begin
    bus.jogar = 0; bus.restart = 0; bus.buttons = 4'b0000; bus.render_finish = 0;
    bus.apple_eaten = 0; bus.collision = 0; bus.max_size = 0;

    #12;
    chk("reset_state", int'(bus.db_estado), 0);
    chk("reset_outs", int'({dut_moore(), bus.render_count, bus.register_direction}), 0);
    cyc(1);
    reset = 1;

    bus.restart = 1;
    cyc(2);
    chk("restart_in_idle", int'(bus.db_estado), 0);
    bus.restart = 0;

    n_rc = 0; n_esp = 0; n_clr = 0; n_ra = 0; n_rd = 0; n_mv = 0;
    bus.jogar = 1;
    cyc(1);
    bus.jogar = 0;
    chk("seq_prepara", int'(bus.db_estado), 1);
    cyc(1); chk("seq_nova_maca", int'(bus.db_estado), 2);
    cyc(1); chk("seq_limpa", int'(bus.db_estado), 8);
    cyc(1); chk("seq_renderiza", int'(bus.db_estado), 3);
    chk("clear_size_once", n_clr, 1);
    chk("reset_apple_once", n_ra, 1);
    cyc(2);
    bus.render_finish = 1;
    cyc(1);
    bus.render_finish = 0;
    chk("render_count_cycles", n_rc, 3);
    chk("entered_espera", int'(bus.db_estado), 4);
    bus.buttons = 4'b0100;
    cyc(1);
    bus.buttons = 4'b0000;
    wait_state(5, 20);
    chk("espera_cycles", n_esp, MT);
    chk("register_direction_cycles", n_rd, 1);
    chk("move_pulse", n_mv, 1);

    bus.apple_eaten = 1;
    cyc(1); chk("verifica", int'(bus.db_estado), 6);
    cyc(1); chk("cresce", int'(bus.db_estado), 7);
    chk("count_size_hi", int'(bus.count_size), 1);
    bus.apple_eaten = 0;
    cyc(1); chk("after_cresce", int'(bus.db_estado), 2);
    bus.render_finish = 1;
    wait_state(5, 30);
    bus.apple_eaten = 1; bus.max_size = 1;
    wait_state(10, 10);
    cyc(3);
    chk("won_held_state", int'(bus.db_estado), 10);
    chk("won_held", int'(bus.won), 1);
    bus.apple_eaten = 0; bus.max_size = 0;
    bus.jogar = 1;
    cyc(1);
    bus.jogar = 0;
    chk("replay_from_won", int'(bus.db_estado), 1);

    wait_state(5, 30);
    bus.collision = 1; bus.apple_eaten = 1;
    n_cs = 0;
    wait_state(9, 10);
    cyc(1);
    chk("loss_no_count_size", n_cs, 0);
    chk("game_over_hi", int'(bus.game_over), 1);
    bus.collision = 0; bus.apple_eaten = 0;
    bus.jogar = 1; bus.restart = 1;
    cyc(1);
    bus.jogar = 0; bus.restart = 0;
    chk("jogar_restart_from_lost", int'(bus.db_estado), 1);

    wait_state(4, 30);
    cyc(2);
    bus.restart = 1;
    cyc(1);
    bus.restart = 0;
    chk("restart_mid_espera", int'(bus.db_estado), 1);
    wait_state(4, 30);
    n_esp = 0;
    wait_state(5, 20);
    chk("espera_after_restart", n_esp, MT - 1);

    bus.render_finish = 0;
    wait_state(3, 30);
    cyc(1);
    #2;
    reset = 0;
    #1;
    chk("async_reset_state", int'(bus.db_estado), 0);
    chk("async_reset_outs", int'({dut_moore(), bus.render_count, bus.register_direction}), 0);
    cyc(1);
    reset = 1;
    cyc(2);
    chk("idle_after_reset", int'(bus.db_estado), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
